ov7670_stream_gen: RTL and testbench

OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

---
 rtl/ov7670_stream_gen.sv | 176 +++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670-style camera timing and test-pattern source.
// Produces VSYNC/HREF framing plus RGB565 pixel bytes (two clocks per pixel),
// running frames back-to-back while run is held high.
module ov7670_stream_gen #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int HBLANK       = 144,
    parameter int VSYNC_LINES  = 3,
    parameter int VBACK_LINES  = 17,
    parameter int VFRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  mode,
    input  logic [11:0] solid,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  dout,
    output logic        frame_start,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int LINE_LEN = 2 * WIDTH + HBLANK;

    localparam logic [15:0] LAST_COL     = 16'(LINE_LEN - 1);
    localparam logic [15:0] ACTIVE_COLS  = 16'(2 * WIDTH);
    localparam logic [15:0] LAST_VSYNC   = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] LAST_VBACK   = 16'(VBACK_LINES - 1);
    localparam logic [15:0] LAST_ACTIVE  = 16'(HEIGHT - 1);
    localparam logic [15:0] LAST_VFRONT  = 16'(VFRONT_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] col;
    logic [15:0] col_nxt;
    logic [15:0] row;
    logic [15:0] row_nxt;
    logic [15:0] last_row;

    logic [1:0]  mode_q;
    logic [11:0] solid_q;

    logic        enter_vsync;
    logic        done_nxt;
    logic        href_nxt;
    logic [7:0]  dout_nxt;
    logic [14:0] pix_x;
    logic [2:0]  bar;
    logic [11:0] colour;
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;

    // State, column and line counters; the counters restart in every region.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    // Next-state logic: walk each region line by line, stop only at a frame boundary.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        last_row  = '0;
        unique case (state)
            VSYNC:   last_row = LAST_VSYNC;
            VBACK:   last_row = LAST_VBACK;
            ACTIVE:  last_row = LAST_ACTIVE;
            VFRONT:  last_row = LAST_VFRONT;
            default: last_row = '0;
        endcase
        if (state == IDLE) begin
            col_nxt = '0;
            row_nxt = '0;
            if (run) begin
                state_nxt = VSYNC;
            end
        end else if (col == LAST_COL) begin
            col_nxt = '0;
            if (row == last_row) begin
                row_nxt = '0;
                unique case (state)
                    VSYNC:   state_nxt = VBACK;
                    VBACK:   state_nxt = ACTIVE;
                    ACTIVE:  state_nxt = VFRONT;
                    VFRONT:  state_nxt = run ? VSYNC : IDLE;
                    default: state_nxt = IDLE;
                endcase
            end else begin
                row_nxt = row + 16'd1;
            end
        end else begin
            col_nxt = col + 16'd1;
        end
    end

    // Pixel pipeline: derive the byte for the upcoming cycle from the next counter values.
    always_comb begin
        enter_vsync = (state_nxt == VSYNC) && (state != VSYNC);
        done_nxt    = (state_nxt == VFRONT) && (col_nxt == LAST_COL) && (row_nxt == LAST_VFRONT);
        href_nxt    = (state_nxt == ACTIVE) && (col_nxt < ACTIVE_COLS);
        pix_x       = col_nxt[15:1];
        bar         = 3'((int'(pix_x) * 8) / WIDTH);
        colour      = 12'h000;
        unique case (mode_q)
            2'd0: begin
                unique case (bar)
                    3'd0:    colour = 12'hFFF;
                    3'd1:    colour = 12'hFF0;
                    3'd2:    colour = 12'h0FF;
                    3'd3:    colour = 12'h0F0;
                    3'd4:    colour = 12'hF0F;
                    3'd5:    colour = 12'hF00;
                    3'd6:    colour = 12'h00F;
                    default: colour = 12'h000;
                endcase
            end
            2'd1:    colour = {pix_x[3:0], row_nxt[3:0], frame_cnt[3:0]};
            2'd2:    colour = solid_q;
            default: colour = (pix_x[3] ^ row_nxt[3]) ? 12'hFFF : 12'h000;
        endcase
        r5 = {colour[11:8], colour[11]};
        g6 = {colour[7:4], colour[7:6]};
        b5 = {colour[3:0], colour[3]};
        dout_nxt = 8'h00;
        if (href_nxt) begin
            dout_nxt = col_nxt[0] ? {g6[2:0], b5} : {r5, g6[5:3]};
        end
    end

    // Registered outputs, frame counter and per-frame latch of mode/solid.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync       <= 1'b0;
            href        <= 1'b0;
            dout        <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 8'h00;
            mode_q      <= 2'd0;
            solid_q     <= 12'h000;
        end else begin
            vsync       <= (state_nxt == VSYNC);
            href        <= href_nxt;
            dout        <= dout_nxt;
            frame_start <= enter_vsync;
            frame_done  <= done_nxt;
            if (done_nxt) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (enter_vsync) begin
                mode_q  <= mode;
                solid_q <= solid;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: scoreboard bench for the OV7670 stream generator.
// Expected pixel bytes are queued by the stimulus; a monitor pops and compares them.
module tb_ov7670_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [1:0]  mode;
    logic [11:0] solid;
    logic        vsync;
    logic        href;
    logic [7:0]  dout;
    logic        frame_start;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b;

    ov7670_stream_gen #(
        .WIDTH(8), .HEIGHT(4), .HBLANK(4),
        .VSYNC_LINES(1), .VBACK_LINES(1), .VFRONT_LINES(1)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .mode(mode), .solid(solid),
        .vsync(vsync), .href(href), .dout(dout),
        .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Free-running pixel clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [11:0] c);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = {c[11:8], c[11]};
        g = {c[7:4], c[7:6]};
        b = {c[3:0], c[3]};
        return {r, g, b};
    endfunction

    // One frame of a constant byte pair (4 lines x 8 pixels)
    task automatic push_solid(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(b0);
            exp_q.push_back(b1);
        end
    endtask

    // Eight bars, one pixel each: white yellow cyan green magenta red blue black
    task automatic push_bars();
        logic [7:0] bars [16];
        bars = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        for (int y = 0; y < 4; y++) begin
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(bars[i]);
            end
        end
    endtask

    // Gradient frame {x, y, completed-frame count}
    task automatic push_gradient(input logic [3:0] fc);
        logic [15:0] w;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                w = to565({4'(x), 4'(y), fc});
                exp_q.push_back(w[15:8]);
                exp_q.push_back(w[7:0]);
            end
        end
    endtask

    task automatic run_until_done(input int limit, output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply_stimulus();
        int n;
        rst = 1'b1; run = 1'b0; mode = 2'd0; solid = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_vsync", 32'(vsync), 0);
        check_output("rst_href", 32'(href), 0);
        check_output("rst_dout", 32'(dout), 0);
        check_output("rst_frame_start", 32'(frame_start), 0);
        check_output("rst_frame_done", 32'(frame_done), 0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: solid F80 -> R5=1F, G6=22, B5=00 -> bytes FC, 40; run dropped mid-ACTIVE
        mode = 2'd2; solid = 12'hF80;
        push_solid(8'hFC, 8'h40);
        run = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 50) run = 1'b0;
            check_output("t_vsync", 32'(vsync), 32'(c <= 20));
            check_output("t_frame_start", 32'(frame_start), 32'(c == 1));
            check_output("t_frame_done", 32'(frame_done), 32'(c == 140));
            check_output("t_href", 32'(href), 32'(c >= 41 && c <= 120 && ((c - 41) % 20) < 16));
            if (c == 139) check_output("frame_cnt_before", 32'(frame_cnt), 0);
            if (c == 140) check_output("frame_cnt_after", 32'(frame_cnt), 1);
        end

        // Frame 2: restart, solid green; switch to mode 3 mid-frame
        mode = 2'd2; solid = 12'h0F0;
        push_solid(8'h07, 8'hE0);
        run = 1'b1;
        @(negedge clk);
        check_output("restart_vsync", 32'(vsync), 1);
        check_output("restart_frame_start", 32'(frame_start), 1);
        repeat (59) @(negedge clk);
        mode = 2'd3;
        push_solid(8'h00, 8'h00);
        run_until_done(200, n);
        check_output("f2_done_delay", 32'(n), 80);
        check_output("f2_frame_cnt", 32'(frame_cnt), 2);

        // Frame 3: checkerboard (all black at this size); switch to bars mid-frame
        @(negedge clk);
        check_output("f3_vsync", 32'(vsync), 1);
        check_output("f3_frame_start", 32'(frame_start), 1);
        repeat (59) @(negedge clk);
        mode = 2'd0;
        push_bars();
        run_until_done(200, n);
        check_output("f3_done_delay", 32'(n), 80);
        check_output("f3_frame_cnt", 32'(frame_cnt), 3);

        // Frame 4: bars; switch to gradient mid-frame
        @(negedge clk);
        repeat (59) @(negedge clk);
        mode = 2'd1;
        push_gradient(4'd4);
        run_until_done(200, n);
        check_output("f4_done_delay", 32'(n), 80);
        check_output("f4_frame_cnt", 32'(frame_cnt), 4);
        check_output("f4_queue_left", 32'(exp_q.size()), 64);

        // Frame 5: gradient, reset during ACTIVE line 2 (col 4 of that line)
        repeat (85) @(negedge clk);
        rst = 1'b1; run = 1'b0;
        @(negedge clk);
        check_output("mid_rst_vsync", 32'(vsync), 0);
        check_output("mid_rst_href", 32'(href), 0);
        check_output("mid_rst_dout", 32'(dout), 0);
        check_output("mid_rst_frame_start", 32'(frame_start), 0);
        check_output("mid_rst_frame_done", 32'(frame_done), 0);
        check_output("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check_output("mid_rst_queue_left", 32'(exp_q.size()), 27);
        exp_q.delete();
        rst = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            check_output("post_rst_frame_done", 32'(frame_done), 0);
            check_output("post_rst_vsync", 32'(vsync), 0);
        end
    endtask

    // Monitor: compare every active byte against the scoreboard, idle bytes against zero
    always @(negedge clk) begin
        if (href === 1'b1) begin
            check_output("sb_not_empty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check_output("pixel_byte", 32'(dout), 32'(exp_b));
            end
        end else begin
            check_output("dout_idle", 32'(dout), 0);
        end
    end

    initial begin
        apply_stimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
